instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
Sequences Z80 instruction fetch. Pulls bytes from memory one at a time and assembles them little-endian into a 32-bit buffer. Drives the combinational length/group decoder and the IX/IY bit-op decoder, fetching further opcode bytes and then operand bytes until the instruction is complete. Sits between the memory port and the execute stage, and presents one complete instruction, with its length, group and start PC, over a valid/ready handshake.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_rd  out  1  byte read request
mem_addr  out  16  read address (= pc)
mem_data  in  8  read data; valid when mem_ready=1
mem_ready  in  1  read completes this cycle when mem_rd=1
dec_instr  out  32  buffer to length decoder
dec_op_len  out  2  opcode bytes held (to decoder)
dec_len  in  3  total length from decoder
dec_group  in  8  group from decoder
ixiy_group  in  8  group from bit-op decoder, fed with insn[31:24]
pc_load  in  1  redirect fetch
pc_in  in  16  new PC when pc_load=1
insn  out  32  assembled instruction, byte 0 in [7:0], unused bytes zero
insn_len  out  3  instruction length
insn_group  out  8  final group code
insn_pc  out  16  address of the first byte
insn_valid  out  1  instruction available
insn_ready  in  1  consumer accepts

Behaviour:
- Reset: state S_OPC, pc=RESET_PC, buf=0, count=0, op_len=0, insn_len=0, insn_group=0, insn_pc=RESET_PC, mem_rd=0 is not guaranteed (mem_rd is combinational from state), insn_valid=0.
- Registers: pc[15:0], buf[31:0], count[2:0] (bytes held), op_len[1:0], len_r[2:0], grp_r[7:0], start_pc[15:0].
- dec_instr=buf and dec_op_len=op_len, both combinational. insn=buf.
- A byte transfer occurs when mem_rd && mem_ready:
  - buf[8*count +: 8] <= mem_data; count++; pc++.
  - PC wraps 16'hFFFF -> 16'h0000.
  - When count==0, start_pc <= pc.
- mem_rd=1 only in S_OPC and S_OPR. mem_addr=pc always.
- S_OPC (fetch opcode byte): on transfer, op_len <= count+1, then go to S_DEC. Otherwise hold.
- S_DEC (one cycle, no fetch):
  - If dec_group==`INSN_GROUP_NEED_MORE_BYTES and op_len<2: go to S_OPC.
  - Otherwise latch len_r=dec_len and grp_r=dec_group.
    - If count==dec_len: go to S_FIN.
    - Else: go to S_OPR.
  - `INSN_GROUP_ILLEGAL_INSTR` is not special-cased; it is presented with the decoder's length.
- S_OPR: transfer operand bytes. When a transfer makes count==len_r, go to S_FIN.
- S_FIN (one cycle):
  - If grp_r==`INSN_GROUP_IDX_IXIY_BITS: grp_r <= ixiy_group, sampled with buf[31:24] complete.
  - Go to S_DONE.
- S_DONE:
  - insn_valid=1, insn_len=len_r, insn_group=grp_r, insn_pc=start_pc.
  - All outputs are stable while insn_ready=0.
  - On insn_ready: buf=0, count=0, op_len=0, go to S_OPC. The next fetch starts on the following cycle.
- Latency with zero wait states: 1-byte instruction is valid 3 cycles after fetch start (OPC, DEC, FIN). Each additional byte adds 1 cycle, and each extra opcode byte also adds a DEC cycle. Each mem_ready=0 cycle adds 1.
- pc_load, in any state, has highest priority:
  - pc <= pc_in; buf=0, count=0, op_len=0; go to S_OPC.
  - Any transfer in that same cycle is discarded.
  - pc_load together with insn_ready in S_DONE: the instruction counts as consumed, and the redirect is taken.
- Reset asserted mid-fetch or mid-handshake: immediate return to reset values. The partial instruction is dropped.
- count never exceeds 4. len_r is always 1..4.

Test Plan:
1. Memory 0000:00, mem_ready=1 always, insn_ready=1 → insn_valid on cycle 3: insn=0x00000000, len=1, group NOP, insn_pc=0000. Next fetch at 0001.
2. Memory 0000: 01 34 12 → insn=0x00123401, len=3, group LD_DD_NN, insn_pc=0000; pc=0003 afterward. With mem_ready low for 2 cycles on byte 1, valid arrives 2 cycles later.
3. Memory 0000: DD CB 05 06 → two S_DEC passes; insn=0x0605CBDD, len=4, group RR_RLC_IDX_IXIY. With byte 3 = 0xFF instead, group is ILLEGAL_INSTR.
4. Backpressure: hold insn_ready=0 for 5 cycles on ED 44 → insn=0x000044ED, group NEG, len=2, all stable; mem_rd=0 throughout. Release → fetch resumes at 0002.
5. pc_load pc_in=0x8000 while in S_OPR of 21 xx xx (LD HL,nn) → mem_addr=8000 next cycle, buffer cleared, no stale valid. pc_load with insn_ready in S_DONE → single consume, fetch at 8000.
6. PC wrap: pc_load 0xFFFF, memory FFFF:3E, 0000:55 → insn=0x0000553E, len=2, insn_pc=FFFF, pc=0001. Reset asserted mid-operand → insn_valid=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/instr_fetch_sequencer_if.sv
// Memory read port and instruction hand-off of the Z80 fetch sequencer.
// master = the sequencer side, slave = memory/execute environment side.
interface instr_fetch_sequencer_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;

    logic [31:0] insn;
    logic [2:0]  insn_len;
    logic [7:0]  insn_group;
    logic [15:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;

    modport master (
        output mem_rd, mem_addr, insn, insn_len, insn_group, insn_pc, insn_valid,
        input  mem_data, mem_ready, insn_ready
    );

    modport slave (
        input  mem_rd, mem_addr, insn, insn_len, insn_group, insn_pc, insn_valid,
        output mem_data, mem_ready, insn_ready
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Z80 instruction fetch sequencer: assembles opcode and operand bytes little-endian,
// consults the external length/group decoders and hands out whole instructions.
`ifndef INSN_GROUP_NEED_MORE_BYTES
`define INSN_GROUP_NEED_MORE_BYTES 8'hFF
`endif
`ifndef INSN_GROUP_IDX_IXIY_BITS
`define INSN_GROUP_IDX_IXIY_BITS 8'hFE
`endif

module instr_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                           clk,
    input  logic                           reset,
    instr_fetch_sequencer_if.master        bus,
    output logic [31:0]                    dec_instr,
    output logic [1:0]                     dec_op_len,
    input  logic [2:0]                     dec_len,
    input  logic [7:0]                     dec_group,
    input  logic [7:0]                     ixiy_group,
    input  logic                           pc_load,
    input  logic [15:0]                    pc_in
);

    typedef enum logic [2:0] {
        S_OPC,
        S_DEC,
        S_OPR,
        S_FIN,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] start_pc;
    logic [31:0] ibuf;
    logic [2:0]  count;
    logic [1:0]  op_len;
    logic [2:0]  len_r;
    logic [7:0]  grp_r;
    logic        xfer;
    logic        need_more;

    assign bus.mem_rd   = (state == S_OPC) || (state == S_OPR);
    assign bus.mem_addr = pc;
    assign xfer         = bus.mem_rd && bus.mem_ready;
    assign need_more    = (dec_group == `INSN_GROUP_NEED_MORE_BYTES) && (op_len < 2'd2);

    assign dec_instr      = ibuf;
    assign dec_op_len     = op_len;
    assign bus.insn       = ibuf;
    assign bus.insn_len   = len_r;
    assign bus.insn_group = grp_r;
    assign bus.insn_pc    = start_pc;
    assign bus.insn_valid = (state == S_DONE);

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_OPC:  if (xfer) state_next = S_DEC;
            S_DEC: begin
                if (need_more)             state_next = S_OPC;
                else if (count == dec_len) state_next = S_FIN;
                else                       state_next = S_OPR;
            end
            S_OPR:  if (xfer && (count + 3'd1 == len_r)) state_next = S_FIN;
            S_FIN:  state_next = S_DONE;
            S_DONE: if (bus.insn_ready) state_next = S_OPC;
            default: state_next = S_OPC;
        endcase
        if (pc_load) state_next = S_OPC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_OPC;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            start_pc <= RESET_PC;
            ibuf     <= '0;
            count    <= '0;
            op_len   <= '0;
            len_r    <= '0;
            grp_r    <= '0;
        end else if (pc_load) begin
            pc     <= pc_in;
            ibuf   <= '0;
            count  <= '0;
            op_len <= '0;
        end else begin
            if (xfer) begin
                ibuf  <= ibuf | (32'(bus.mem_data) << {count[1:0], 3'b000});
                count <= count + 3'd1;
                pc    <= pc + 16'd1;
                if (count == 3'd0) start_pc <= pc;
            end
            case (state)
                S_OPC: if (xfer) op_len <= count[1:0] + 2'd1;
                S_DEC: begin
                    if (!need_more) begin
                        len_r <= dec_len;
                        grp_r <= dec_group;
                    end
                end
                // IX/IY bit ops are only known once the trailing opcode byte is in buf[31:24]
                S_FIN: if (grp_r == `INSN_GROUP_IDX_IXIY_BITS) grp_r <= ixiy_group;
                S_DONE: begin
                    if (bus.insn_ready) begin
                        ibuf   <= '0;
                        count  <= '0;
                        op_len <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer with a small Z80 decoder model
// and a byte-wide memory model.
`ifndef INSN_GROUP_NEED_MORE_BYTES
`define INSN_GROUP_NEED_MORE_BYTES 8'hFF
`endif
`ifndef INSN_GROUP_IDX_IXIY_BITS
`define INSN_GROUP_IDX_IXIY_BITS 8'hFE
`endif
`ifndef INSN_GROUP_ILLEGAL_INSTR
`define INSN_GROUP_ILLEGAL_INSTR 8'hFD
`endif
`ifndef INSN_GROUP_NOP
`define INSN_GROUP_NOP 8'h00
`endif
`ifndef INSN_GROUP_LD_DD_NN
`define INSN_GROUP_LD_DD_NN 8'h01
`endif
`ifndef INSN_GROUP_NEG
`define INSN_GROUP_NEG 8'h02
`endif
`ifndef INSN_GROUP_RR_RLC_IDX_IXIY
`define INSN_GROUP_RR_RLC_IDX_IXIY 8'h03
`endif
`ifndef INSN_GROUP_LD_R_N
`define INSN_GROUP_LD_R_N 8'h04
`endif

module tb_instr_fetch_sequencer;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [7:0]  grp;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dec_instr;
    logic [1:0]  dec_op_len;
    logic [2:0]  dec_len;
    logic [7:0]  dec_group;
    logic [7:0]  ixiy_group;
    logic        pc_load;
    logic [15:0] pc_in;
    logic [7:0]  mem [0:65535];

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    instr_fetch_sequencer_if ifc ();

    instr_fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (ifc),
        .dec_instr  (dec_instr),
        .dec_op_len (dec_op_len),
        .dec_len    (dec_len),
        .dec_group  (dec_group),
        .ixiy_group (ixiy_group),
        .pc_load    (pc_load),
        .pc_in      (pc_in)
    );

    always #5 clk = ~clk;

    assign ifc.mem_data = mem[ifc.mem_addr];

    // Reference decoder: only the opcodes the vectors use
    always_comb begin
        dec_len   = 3'd1;
        dec_group = `INSN_GROUP_ILLEGAL_INSTR;
        if (dec_op_len == 2'd1) begin
            case (dec_instr[7:0])
                8'h00: begin dec_len = 3'd1; dec_group = `INSN_GROUP_NOP; end
                8'h01, 8'h21: begin dec_len = 3'd3; dec_group = `INSN_GROUP_LD_DD_NN; end
                8'h3E: begin dec_len = 3'd2; dec_group = `INSN_GROUP_LD_R_N; end
                8'hDD, 8'hFD, 8'hED, 8'hCB: dec_group = `INSN_GROUP_NEED_MORE_BYTES;
                default: ;
            endcase
        end else if (dec_op_len == 2'd2) begin
            dec_len = 3'd2;
            if (dec_instr[15:0] == 16'h44ED) begin
                dec_group = `INSN_GROUP_NEG;
            end else if (dec_instr[15:8] == 8'hCB && (dec_instr[7:0] == 8'hDD || dec_instr[7:0] == 8'hFD)) begin
                dec_len   = 3'd4;
                dec_group = `INSN_GROUP_IDX_IXIY_BITS;
            end
        end
    end

    always_comb begin
        ixiy_group = `INSN_GROUP_ILLEGAL_INSTR;
        if (ifc.insn[31:24] == 8'h06) ixiy_group = `INSN_GROUP_RR_RLC_IDX_IXIY;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [2:0] l, input logic [7:0] g, input logic [15:0] p);
        exp_t e;
        e.insn = i; e.len = l; e.grp = g; e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] addr);
        pc_load = 1'b1;
        pc_in   = addr;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input int req_cycles, input string name);
        int cycles = 0;
        while (!ifc.insn_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        check(name, 64'(cycles), 64'(req_cycles));
    endtask

    // Stall memory, then let the pending instruction be consumed on the next edge
    task automatic finish_insn();
        ifc.mem_ready = 1'b0;
        tick();
    endtask

    // Monitor: a handshake completes on the coming edge whenever valid && ready
    always @(negedge clk) begin
        if (!reset && ifc.insn_valid && ifc.insn_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_insn actual=0x%0h required=none", ifc.insn);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_insn",  64'(ifc.insn),       64'(mon_e.insn));
                check("sb_len",   64'(ifc.insn_len),   64'(mon_e.len));
                check("sb_group", 64'(ifc.insn_group), 64'(mon_e.grp));
                check("sb_pc",    64'(ifc.insn_pc),    64'(mon_e.pc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        pc_load = 1'b0;
        pc_in = 16'h0000;
        ifc.mem_ready = 1'b0;
        ifc.insn_ready = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        // 1: NOP at 0000, reset values, 3-cycle latency
        tick();
        tick();
        check("rst_valid", 64'(ifc.insn_valid), 64'd0);
        check("rst_addr", 64'(ifc.mem_addr), 64'h0000);
        check("rst_insn", 64'(ifc.insn), 64'd0);
        check("rst_len_grp_pc", 64'({ifc.insn_len, ifc.insn_group, ifc.insn_pc}), 64'd0);
        check("rst_op_len", 64'(dec_op_len), 64'd0);
        push_exp(32'h0000_0000, 3'd1, `INSN_GROUP_NOP, 16'h0000);
        reset = 1'b0;
        ifc.mem_ready = 1'b1;
        wait_valid(20, 3, "t1_latency");
        finish_insn();
        check("t1_next_addr", 64'(ifc.mem_addr), 64'h0001);

        // 2: LD BC,1234 with and without wait states
        mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12;
        do_reset();
        push_exp(32'h0012_3401, 3'd3, `INSN_GROUP_LD_DD_NN, 16'h0000);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 5, "t2_latency");
        finish_insn();
        check("t2_pc_after", 64'(ifc.mem_addr), 64'h0003);

        do_reset();
        push_exp(32'h0012_3401, 3'd3, `INSN_GROUP_LD_DD_NN, 16'h0000);
        ifc.mem_ready = 1'b1;
        tick();
        tick();
        ifc.mem_ready = 1'b0;
        tick();
        check("t2_wait_addr", 64'({ifc.mem_rd, ifc.mem_addr}), 64'({1'b1, 16'h0001}));
        tick();
        ifc.mem_ready = 1'b1;
        wait_valid(20, 3, "t2_wait_latency");
        finish_insn();

        // 3: DD CB 05 06 and DD CB 05 FF
        mem[16'h0020] = 8'hDD; mem[16'h0021] = 8'hCB; mem[16'h0022] = 8'h05; mem[16'h0023] = 8'h06;
        mem[16'h0030] = 8'hDD; mem[16'h0031] = 8'hCB; mem[16'h0032] = 8'h05; mem[16'h0033] = 8'hFF;
        push_exp(32'h0605_CBDD, 3'd4, `INSN_GROUP_RR_RLC_IDX_IXIY, 16'h0020);
        redirect(16'h0020);
        ifc.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t3_op_len2", 64'(dec_op_len), 64'd2);
        wait_valid(20, 4, "t3_latency");
        finish_insn();
        push_exp(32'hFF05_CBDD, 3'd4, `INSN_GROUP_ILLEGAL_INSTR, 16'h0030);
        redirect(16'h0030);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 7, "t3_illegal_latency");
        finish_insn();

        // 4: NEG held under backpressure
        mem[0] = 8'hED; mem[1] = 8'h44;
        ifc.insn_ready = 1'b0;
        do_reset();
        push_exp(32'h0000_44ED, 3'd2, `INSN_GROUP_NEG, 16'h0000);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 5, "t4_latency");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_stable",
                  64'({ifc.insn_valid, ifc.mem_rd, ifc.insn, ifc.insn_len, ifc.insn_group, ifc.insn_pc}),
                  64'({1'b1, 1'b0, 32'h0000_44ED, 3'd2, `INSN_GROUP_NEG, 16'h0000}));
        end
        ifc.mem_ready = 1'b0;
        ifc.insn_ready = 1'b1;
        tick();
        check("t4_resume", 64'({ifc.insn_valid, ifc.mem_addr}), 64'({1'b0, 16'h0002}));

        // 5: redirect during operand fetch, then redirect together with consume
        mem[16'h0050] = 8'h21; mem[16'h0051] = 8'hAA; mem[16'h0052] = 8'hBB;
        redirect(16'h0050);
        ifc.mem_ready = 1'b1;
        tick();
        tick();
        check("t5_in_opr", 64'({ifc.mem_rd, ifc.mem_addr}), 64'({1'b1, 16'h0051}));
        pc_load = 1'b1;
        pc_in = 16'h8000;
        tick();
        pc_load = 1'b0;
        ifc.mem_ready = 1'b0;
        check("t5_redirect", 64'({ifc.mem_addr, dec_op_len, ifc.insn}), 64'({16'h8000, 2'd0, 32'd0}));
        repeat (3) tick();
        check("t5_no_stale_valid", 64'(ifc.insn_valid), 64'd0);

        mem[16'h0060] = 8'h00;
        mem[16'h8000] = 8'h00;
        ifc.insn_ready = 1'b0;
        push_exp(32'h0000_0000, 3'd1, `INSN_GROUP_NOP, 16'h0060);
        redirect(16'h0060);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 3, "t5_done_latency");
        ifc.mem_ready = 1'b0;
        ifc.insn_ready = 1'b1;
        pc_load = 1'b1;
        pc_in = 16'h8000;
        tick();
        pc_load = 1'b0;
        check("t5_load_consume", 64'({ifc.insn_valid, ifc.mem_addr}), 64'({1'b0, 16'h8000}));
        check("t5_single_consume", 64'(exp_q.size()), 64'd0);
        push_exp(32'h0000_0000, 3'd1, `INSN_GROUP_NOP, 16'h8000);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 3, "t5_fetch_8000");
        finish_insn();

        // 6: PC wrap across FFFF, then reset mid-operand
        mem[16'hFFFF] = 8'h3E; mem[0] = 8'h55;
        push_exp(32'h0000_553E, 3'd2, `INSN_GROUP_LD_R_N, 16'hFFFF);
        redirect(16'hFFFF);
        ifc.mem_ready = 1'b1;
        wait_valid(20, 4, "t6_latency");
        finish_insn();
        check("t6_wrap_pc", 64'(ifc.mem_addr), 64'h0001);

        redirect(16'h0050);
        ifc.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_mid_operand", 64'({ifc.mem_addr, ifc.insn}), 64'({16'h0052, 32'h0000_AA21}));
        reset = 1'b1;
        #1;
        check("t6_reset_async", 64'({ifc.insn_valid, ifc.mem_addr, dec_op_len, ifc.insn}),
              64'({1'b0, 16'h0000, 2'd0, 32'd0}));
        ifc.mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t6_after_reset", 64'({ifc.insn_valid, ifc.mem_addr}), 64'({1'b0, 16'h0000}));

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
